// File: rtl/sd_spi_byte_master_pkg.sv
// Shared constants for the SD-card SPI byte engine: FSM encodings, idle levels and
// default divider values also used by the SD controller for its timeouts.
package sd_spi_byte_master_pkg;

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StLow      = 3'd1;
   localparam logic [2:0] StHigh     = 3'd2;
   localparam logic [2:0] StInitLow  = 3'd3;
   localparam logic [2:0] StInitHigh = 3'd4;

   localparam int unsigned SdInitClocks  = 80;
   localparam logic        SpiIdleMosi   = 1'b1;
   localparam int unsigned DefClkDivSlow = 125;
   localparam int unsigned DefClkDivFast = 2;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sd_spi_clk_div.sv
// Loadable half-period tick generator: counts 0..div-1 while enabled and pulses tick
// on the last count, wrapping back to 0.
module sd_spi_clk_div #(
   parameter int unsigned CntW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic [CntW-1:0] div_i,
   input  logic            en_i,
   output logic            tick_o
);

   logic [CntW-1:0] div_q, div_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            last;

   assign last   = (cnt_q == div_q - CntW'(1));
   assign tick_o = en_i && last;

   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (load_i) begin
         div_d = div_i;
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = last ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sd_spi_byte_master.sv
// SPI mode-0 byte engine for the SD card: shifts a byte MSB-first while sampling miso,
// and generates the power-up dummy clocks with cs_n held high.
module sd_spi_byte_master
   import sd_spi_byte_master_pkg::*;
#(
   parameter int unsigned CLK_DIV_SLOW = DefClkDivSlow,
   parameter int unsigned CLK_DIV_FAST = DefClkDivFast,
   parameter int unsigned INIT_CLOCKS  = SdInitClocks
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       fast_mode,
   input  logic       cs_assert,
   input  logic       init_clk_req,
   output logic [7:0] rx_byte,
   output logic       done,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   localparam int unsigned DivW  = $clog2(max_u(CLK_DIV_SLOW, CLK_DIV_FAST) + 1);
   localparam int unsigned EdgeW = $clog2(INIT_CLOCKS + 1);

   logic [2:0]       state_q, state_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             done_q, done_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic [7:0]       rx_sr_q, rx_sr_d;
   logic [6:0]       tx_sr_q, tx_sr_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [EdgeW-1:0] edge_cnt_q, edge_cnt_d;
   logic             div_load;
   logic [DivW-1:0]  div_val;
   logic             tick;

   assign busy    = (state_q != StIdle);
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;
   assign done    = done_q;
   assign rx_byte = rx_byte_q;

   sd_spi_clk_div #(
      .CntW (DivW)
   ) u_clk_div (
      .clk    (clk),
      .reset  (reset),
      .load_i (div_load),
      .div_i  (div_val),
      .en_i   (busy),
      .tick_o (tick)
   );

   always_comb begin
      state_d    = state_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      done_d     = 1'b0;
      rx_byte_d  = rx_byte_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      bit_cnt_d  = bit_cnt_q;
      edge_cnt_d = edge_cnt_q;
      div_load   = 1'b0;
      div_val    = DivW'(CLK_DIV_SLOW);
      case (state_q)
         StIdle: begin
            cs_n_d = ~cs_assert;
            if (start) begin
               div_load  = 1'b1;
               div_val   = fast_mode ? DivW'(CLK_DIV_FAST) : DivW'(CLK_DIV_SLOW);
               tx_sr_d   = tx_byte[6:0];
               mosi_d    = tx_byte[7];
               bit_cnt_d = 3'd0;
               state_d   = StLow;
            end else if (init_clk_req) begin
               div_load   = 1'b1;
               edge_cnt_d = '0;
               mosi_d     = SpiIdleMosi;
               cs_n_d     = 1'b1;
               state_d    = StInitLow;
            end
         end
         StLow: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_sr_d = {rx_sr_q[6:0], miso};
               state_d = StHigh;
            end
         end
         StHigh: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == 3'd7) begin
                  rx_byte_d = rx_sr_q;
                  done_d    = 1'b1;
                  mosi_d    = SpiIdleMosi;
                  state_d   = StIdle;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  mosi_d    = tx_sr_q[6];
                  tx_sr_d   = {tx_sr_q[5:0], 1'b0};
                  state_d   = StLow;
               end
            end
         end
         StInitLow: begin
            cs_n_d = 1'b1;
            if (tick) begin
               sclk_d  = 1'b1;
               state_d = StInitHigh;
            end
         end
         StInitHigh: begin
            cs_n_d = 1'b1;
            if (tick) begin
               sclk_d = 1'b0;
               if (edge_cnt_q == EdgeW'(INIT_CLOCKS - 1)) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  edge_cnt_d = edge_cnt_q + EdgeW'(1);
                  state_d    = StInitLow;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         sclk_q     <= 1'b0;
         mosi_q     <= SpiIdleMosi;
         cs_n_q     <= 1'b1;
         done_q     <= 1'b0;
         rx_byte_q  <= 8'h00;
         rx_sr_q    <= 8'h00;
         tx_sr_q    <= 7'h00;
         bit_cnt_q  <= 3'd0;
         edge_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         done_q     <= done_d;
         rx_byte_q  <= rx_byte_d;
         rx_sr_q    <= rx_sr_d;
         tx_sr_q    <= tx_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

endmodule

// File: tb/tb_sd_spi_byte_master.sv
// Self-checking bench for sd_spi_byte_master: an SPI card model captures mosi and serves miso,
// and expected values come from the transfer rules (latency, edge counts, byte contents).
module tb_sd_spi_byte_master;

   localparam int unsigned SLOW  = 125;
   localparam int unsigned FAST  = 2;
   localparam int unsigned NINIT = 80;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       fast_mode = 1'b0;
   logic       cs_assert = 1'b0;
   logic       init_clk_req = 1'b0;
   logic       miso;
   logic [7:0] rx_byte;
   logic       done, busy, sclk, mosi, cs_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Card model state
   int         edges = 0;
   logic [7:0] cap = 8'h00;
   int         cyc = 0;
   int         last_rise = 0;
   int         period = 0;
   int         edge_base = 0;
   int         kk;
   logic       loopback = 1'b0;
   logic [7:0] pat = 8'h00;
   int         init_viol = 0;
   logic       in_init = 1'b0;

   sd_spi_byte_master #(
      .CLK_DIV_SLOW (SLOW),
      .CLK_DIV_FAST (FAST),
      .INIT_CLOCKS  (NINIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .tx_byte      (tx_byte),
      .fast_mode    (fast_mode),
      .cs_assert    (cs_assert),
      .init_clk_req (init_clk_req),
      .rx_byte      (rx_byte),
      .done         (done),
      .busy         (busy),
      .sclk         (sclk),
      .mosi         (mosi),
      .miso         (miso),
      .cs_n         (cs_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge sclk) begin
      edges     <= edges + 1;
      cap       <= {cap[6:0], mosi};
      period    <= cyc - last_rise;
      last_rise <= cyc;
   end

   always @(negedge clk) begin
      if (in_init && busy && (cs_n !== 1'b1 || mosi !== 1'b1)) init_viol <= init_viol + 1;
   end

   assign kk = edges - edge_base;

   // Card presents pattern bit 7-k before the k-th rising edge, or echoes mosi in loopback
   always_comb begin
      miso = 1'b1;
      if (loopback) miso = mosi;
      else if (kk >= 0 && kk < 8) miso = pat[3'(7 - kk)];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle
   task automatic run_byte(input logic [7:0] tx, input logic fm, input logic lb,
                           input logic [7:0] pt, output int lat, output int ne,
                           output logic [7:0] got_mosi, output logic [7:0] got_rx,
                           output bit to);
      loopback  = lb;
      pat       = pt;
      edge_base = edges;
      tx_byte   = tx;
      fast_mode = fm;
      start     = 1'b1;
      lat       = 0;
      to        = 1'b1;
      for (int i = 0; i < int'(16 * SLOW + 50); i++) begin
         @(negedge clk);
         start     = 1'b0;
         fast_mode = ~fm;
         lat++;
         if (done) begin
            to = 1'b0;
            break;
         end
      end
      ne       = edges - edge_base;
      got_mosi = cap;
      got_rx   = rx_byte;
   endtask

   initial begin
      int         lat, ne, nd, v0, div;
      logic [7:0] gm, gr, tx, pt, rx0, exp_rx;
      logic       lb, fm;
      bit         to, hit;

      // Reset state
      #12;
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd1);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx", 32'(rx_byte), 32'h00);
      @(negedge clk);
      reset     = 1'b0;
      cs_assert = 1'b1;
      repeat (3) @(negedge clk);
      check("cs_idle_assert", 32'(cs_n), 32'd0);

      // Loopback, fast
      run_byte(8'hA5, 1'b1, 1'b1, 8'h00, lat, ne, gm, gr, to);
      check("t1_timeout", 32'(to), 32'd0);
      check("t1_latency", 32'(lat), 32'(16 * FAST + 1));
      check("t1_edges", 32'(ne), 32'd8);
      check("t1_rx", 32'(gr), 32'hA5);
      check("t1_busy_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("t1_mosi_idle", 32'(mosi), 32'd1);

      // Slow, miso=0
      run_byte(8'h40, 1'b0, 1'b0, 8'h00, lat, ne, gm, gr, to);
      check("t2_timeout", 32'(to), 32'd0);
      check("t2_latency", 32'(lat), 32'(16 * SLOW + 1));
      check("t2_mosi_bits", 32'(gm), 32'h40);
      check("t2_rx", 32'(gr), 32'h00);
      check("t2_period", 32'(period), 32'(2 * SLOW));

      // Randomized bytes against the card model
      for (int it = 0; it < 12; it++) begin
         tx  = 8'($urandom);
         pt  = 8'($urandom);
         lb  = 1'($urandom_range(0, 1));
         fm  = (it != 3);
         div = fm ? int'(FAST) : int'(SLOW);
         exp_rx = lb ? tx : pt;
         run_byte(tx, fm, lb, pt, lat, ne, gm, gr, to);
         check("rnd_timeout", 32'(to), 32'd0);
         check("rnd_latency", 32'(lat), 32'(16 * div + 1));
         check("rnd_edges", 32'(ne), 32'd8);
         check("rnd_mosi", 32'(gm), 32'(tx));
         check("rnd_rx", 32'(gr), 32'(exp_rx));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Start while busy is ignored
      loopback  = 1'b1;
      edge_base = edges;
      tx_byte   = 8'h3C;
      fast_mode = 1'b1;
      start     = 1'b1;
      nd        = 0;
      rx0       = 8'h00;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 5) begin
            tx_byte = 8'hC3;
            start   = 1'b1;
         end
         if (done) begin
            nd++;
            rx0 = rx_byte;
         end
      end
      check("t4_one_done", 32'(nd), 32'd1);
      check("t4_rx_first", 32'(rx0), 32'h3C);

      // Back-to-back: second start lands in the done cycle
      run_byte(8'h12, 1'b1, 1'b1, 8'h00, lat, ne, gm, gr, to);
      check("t4_b1_rx", 32'(gr), 32'h12);
      run_byte(8'hE7, 1'b1, 1'b1, 8'h00, lat, ne, gm, gr, to);
      check("t4_b2_timeout", 32'(to), 32'd0);
      check("t4_b2_latency", 32'(lat), 32'(16 * FAST + 1));
      check("t4_b2_rx", 32'(gr), 32'hE7);
      @(negedge clk);

      // Dummy init clocks
      rx0          = rx_byte;
      v0           = init_viol;
      in_init      = 1'b1;
      edge_base    = edges;
      fast_mode    = 1'b1;
      init_clk_req = 1'b1;
      lat          = 0;
      nd           = 0;
      to           = 1'b1;
      for (int i = 0; i < int'(2 * SLOW * NINIT + 100); i++) begin
         @(negedge clk);
         init_clk_req = 1'b0;
         lat++;
         if (done) begin
            to = 1'b0;
            break;
         end
      end
      check("t3_timeout", 32'(to), 32'd0);
      check("t3_latency", 32'(lat), 32'(2 * SLOW * NINIT + 1));
      check("t3_edges", 32'(edges - edge_base), 32'(NINIT));
      check("t3_rx_kept", 32'(rx_byte), 32'(rx0));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      in_init = 1'b0;
      check("t3_cs_mosi_high", 32'(init_viol - v0), 32'd0);
      check("t3_no_extra_done", 32'(nd), 32'd0);
      check("t3_cs_back", 32'(cs_n), 32'd0);

      // Reset in bit 3 high phase of a fast byte
      loopback  = 1'b0;
      pat       = 8'hFF;
      edge_base = edges;
      tx_byte   = 8'h00;
      fast_mode = 1'b1;
      start     = 1'b1;
      hit       = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (kk == 4 && sclk === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      check("t5_reached", 32'(hit), 32'd1);
      check("t5_cs_before", 32'(cs_n), 32'd0);
      reset = 1'b1;
      #1;
      check("t5_sclk", 32'(sclk), 32'd0);
      check("t5_mosi", 32'(mosi), 32'd1);
      check("t5_cs_n", 32'(cs_n), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_rx", 32'(rx_byte), 32'h00);
      @(negedge clk);
      reset = 1'b0;
      nd    = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("t5_no_done", 32'(nd), 32'd0);

      // cs_n only follows cs_assert in IDLE
      cs_assert = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_cs_high", 32'(cs_n), 32'd1);
      loopback  = 1'b1;
      edge_base = edges;
      tx_byte   = 8'h5A;
      fast_mode = 1'b1;
      start     = 1'b1;
      v0        = 0;
      hit       = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 3) cs_assert = 1'b1;
         if (cs_n !== 1'b1) v0++;
         if (done) begin
            hit = 1'b1;
            break;
         end
      end
      check("t6_done_seen", 32'(hit), 32'd1);
      check("t6_cs_held", 32'(v0), 32'd0);
      @(negedge clk);
      check("t6_cs_after_done", 32'(cs_n), 32'd0);
      cs_assert = 1'b0;
      @(negedge clk);
      check("t6_cs_deassert", 32'(cs_n), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
